// File: rtl/dcache_arb_pkg.sv
// Shared types and the round-robin pick helper for the D$ port arbiter.
package dcache_arb_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Upper bound on requesters the pick helper can scan.
  localparam int unsigned MaxReq  = 8;
  localparam int unsigned IdxMaxW = 3;

  typedef logic [IdxMaxW-1:0] idx_t;
  typedef logic [IdxMaxW:0]   idx_ext_t;

  // First valid index at or after ptr, wrapping modulo num; returns ptr if none valid.
  function automatic idx_t rr_pick(input logic [MaxReq-1:0] valid,
                                   input idx_t              ptr,
                                   input idx_ext_t          num);
    idx_t     pick;
    logic     found;
    idx_ext_t cand;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < int'(MaxReq); i++) begin
      cand = idx_ext_t'(ptr) + idx_ext_t'(i);
      if (cand >= num) begin
        cand = cand - num;
      end else begin
        cand = cand;
      end
      if (!found && (idx_ext_t'(i) < num) && valid[cand[IdxMaxW-1:0]]) begin
        pick  = cand[IdxMaxW-1:0];
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/dcache_arb_chk.sv
// Requester obligation: a stalled request keeps valid and its fields until accepted.
module dcache_arb_chk #(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64
) (
  input logic                   clk_i,
  input logic                   rst_i,
  input logic                   mem_valid_i,
  input logic                   mem_ready_i,
  input logic [AddrWidth-1:0]   mem_addr_i,
  input logic                   mem_we_i,
  input logic [DataWidth-1:0]   mem_wdata_i,
  input logic [DataWidth/8-1:0] mem_be_i
);

  a_stall_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (mem_valid_i && !mem_ready_i) |=>
      (mem_valid_i && $stable(mem_addr_i) && $stable(mem_we_i) &&
       $stable(mem_wdata_i) && $stable(mem_be_i)));

endmodule

// File: rtl/dcache_arb_id_fifo.sv
// In-order FIFO of requester indices for accepted-but-unanswered D$ requests.
module dcache_arb_id_fifo
  import dcache_arb_pkg::*;
#(
  parameter int unsigned Width = 2,
  parameter int unsigned Depth = 7
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] head_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push_ok_s, pop_ok_s;

  assign full_o    = (cnt_q == CntW'(Depth));
  assign empty_o   = (cnt_q == {CntW{1'b0}});
  assign head_o    = mem_q[rd_ptr_q];
  assign push_ok_s = push_i & ~full_o;
  assign pop_ok_s  = pop_i & ~empty_o;

  // Pointer and occupancy next-state; pointers wrap at Depth, which need not be a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok_s) begin
      wr_ptr_d = (wr_ptr_q == LastPtr) ? {PtrW{1'b0}} : wr_ptr_q + PtrW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? {PtrW{1'b0}} : rd_ptr_q + PtrW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= {PtrW{1'b0}};
      rd_ptr_q <= {PtrW{1'b0}};
      cnt_q    <= {CntW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is only read under a valid occupancy, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Round-robin arbiter sharing one write-through D$ port among NumReq requesters,
// with in-order response routing through an ID FIFO.
module dcache_port_arbiter
  import dcache_arb_pkg::*;
#(
  parameter int unsigned NumReq    = 3,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned MaxOutstd = 7
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumReq-1:0]             req_valid_i,
  output logic [NumReq-1:0]             req_ready_o,
  input  logic [NumReq*AddrWidth-1:0]   req_addr_i,
  input  logic [NumReq-1:0]             req_we_i,
  input  logic [NumReq*DataWidth-1:0]   req_wdata_i,
  input  logic [NumReq*DataWidth/8-1:0] req_be_i,
  output logic [NumReq-1:0]             rsp_valid_o,
  output logic [DataWidth-1:0]          rsp_rdata_o,
  output logic                          mem_valid_o,
  input  logic                          mem_ready_i,
  output logic [AddrWidth-1:0]          mem_addr_o,
  output logic                          mem_we_o,
  output logic [DataWidth-1:0]          mem_wdata_o,
  output logic [DataWidth/8-1:0]        mem_be_o,
  input  logic                          mem_rvalid_i,
  input  logic [DataWidth-1:0]          mem_rdata_i,
  output logic                          proto_err_o
);

  localparam int unsigned IdxW = $clog2(NumReq);
  localparam int unsigned BeW  = DataWidth / 8;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumReq - 1);

  arb_state_e      state_q, state_d;
  logic [IdxW-1:0] lock_q, lock_d;
  logic [IdxW-1:0] rr_q, rr_d;
  logic            err_q, err_d;
  logic [IdxW-1:0] sel_s;
  logic            sel_vld_s;
  logic            mem_valid_s, hs_s, pop_s;
  logic            fifo_full_s, fifo_empty_s;
  logic [IdxW-1:0] fifo_head_s;

  // While locked only the latched requester is considered, so a stall cannot be stolen.
  always_comb begin
    if (state_q == LOCKED) begin
      sel_s     = lock_q;
      sel_vld_s = req_valid_i[lock_q];
    end else begin
      sel_s     = IdxW'(rr_pick(MaxReq'(req_valid_i), idx_t'(rr_q), idx_ext_t'(NumReq)));
      sel_vld_s = |req_valid_i;
    end
  end

  // Fullness alone gates acceptance; a same-cycle response never frees a slot early.
  assign mem_valid_s = sel_vld_s & ~fifo_full_s & ~rst_i;
  assign hs_s        = mem_valid_s & mem_ready_i;
  assign pop_s       = mem_rvalid_i & ~fifo_empty_s & ~rst_i;

  always_comb begin
    mem_valid_o = mem_valid_s;
    req_ready_o = {NumReq{1'b0}};
    if (mem_valid_s) begin
      mem_addr_o  = req_addr_i[sel_s*AddrWidth +: AddrWidth];
      mem_we_o    = req_we_i[sel_s];
      mem_wdata_o = req_wdata_i[sel_s*DataWidth +: DataWidth];
      mem_be_o    = req_be_i[sel_s*BeW +: BeW];
    end else begin
      mem_addr_o  = {AddrWidth{1'b0}};
      mem_we_o    = 1'b0;
      mem_wdata_o = {DataWidth{1'b0}};
      mem_be_o    = {BeW{1'b0}};
    end
    if (hs_s) begin
      req_ready_o[sel_s] = 1'b1;
    end else begin
      req_ready_o = {NumReq{1'b0}};
    end
  end

  always_comb begin
    rsp_valid_o = {NumReq{1'b0}};
    rsp_rdata_o = {DataWidth{1'b0}};
    if (pop_s) begin
      rsp_valid_o[fifo_head_s] = 1'b1;
      rsp_rdata_o              = mem_rdata_i;
    end else begin
      rsp_valid_o = {NumReq{1'b0}};
    end
  end

  // A locked requester that withdraws releases the port rather than wedging it.
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    rr_d    = rr_q;
    err_d   = err_q | (mem_rvalid_i & fifo_empty_s);
    case (state_q)
      IDLE: begin
        if (mem_valid_s && !mem_ready_i) begin
          state_d = LOCKED;
          lock_d  = sel_s;
        end else begin
          state_d = IDLE;
        end
      end
      LOCKED: begin
        if (!sel_vld_s || hs_s) begin
          state_d = IDLE;
        end else begin
          state_d = LOCKED;
        end
      end
      default: state_d = IDLE;
    endcase
    if (hs_s) begin
      rr_d = (sel_s == LastIdx) ? {IdxW{1'b0}} : sel_s + IdxW'(1);
    end else begin
      rr_d = rr_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      lock_q  <= {IdxW{1'b0}};
      rr_q    <= {IdxW{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
    end
  end

  assign proto_err_o = err_q;

  dcache_arb_id_fifo #(
    .Width (IdxW),
    .Depth (MaxOutstd)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (hs_s),
    .data_i  (sel_s),
    .pop_i   (pop_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .head_o  (fifo_head_s)
  );

  dcache_arb_chk #(
    .AddrWidth (AddrWidth),
    .DataWidth (DataWidth)
  ) u_chk (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .mem_valid_i (mem_valid_o),
    .mem_ready_i (mem_ready_i),
    .mem_addr_i  (mem_addr_o),
    .mem_we_i    (mem_we_o),
    .mem_wdata_i (mem_wdata_o),
    .mem_be_i    (mem_be_o)
  );

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Scoreboard bench: stimulus feeds a queue-based reference model that pushes expected
// grants/responses; a negedge monitor pops and compares them against the DUT.
module tb_dcache_port_arbiter;

  localparam int N  = 3;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int BW = DW / 8;
  localparam int MO = 7;

  logic            clk = 1'b0;
  logic            rst_i;
  logic [N-1:0]    req_valid_i, req_ready_o, req_we_i, rsp_valid_o;
  logic [N*AW-1:0] req_addr_i;
  logic [N*DW-1:0] req_wdata_i;
  logic [N*BW-1:0] req_be_i;
  logic [DW-1:0]   rsp_rdata_o, mem_wdata_o, mem_rdata_i;
  logic            mem_valid_o, mem_ready_i, mem_we_o, mem_rvalid_i, proto_err_o;
  logic [AW-1:0]   mem_addr_o;
  logic [BW-1:0]   mem_be_o;

  always #5 clk = ~clk;

  dcache_port_arbiter #(.NumReq(N), .AddrWidth(AW), .DataWidth(DW), .MaxOutstd(MO)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_we_i(req_we_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .mem_valid_o(mem_valid_o),
    .mem_ready_i(mem_ready_i), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .proto_err_o(proto_err_o));

  typedef struct { logic [N-1:0] ready; logic [AW-1:0] addr; logic we; logic [DW-1:0] wdata; logic [BW-1:0] be; } grant_t;
  typedef struct { logic [N-1:0] owner; logic [DW-1:0] rdata; } rsp_t;
  typedef struct { logic valid; logic err; } cyc_t;

  grant_t grant_q[$];
  rsp_t   rsp_q[$];
  cyc_t   cyc_q[$];

  // Requester-side state: a pending request is held unchanged until it is granted.
  logic [N-1:0]  pend;
  logic [AW-1:0] paddr [N];
  logic          pwe   [N];
  logic [DW-1:0] pwdata[N];
  logic [BW-1:0] pbe   [N];

  // Reference model: outstanding owners in order, RR pointer, stalled winner, error flag.
  int out_q[$];
  int rr;
  int held;
  bit err;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic new_req(input int i, input logic we, input logic [BW-1:0] be);
    pend[i]   = 1'b1;
    paddr[i]  = {$urandom, $urandom};
    pwe[i]    = we;
    pwdata[i] = {$urandom, $urandom};
    pbe[i]    = be;
  endtask

  task automatic refill();
    for (int i = 0; i < N; i++) if (!pend[i]) new_req(i, 1'b0, 8'hFF);
  endtask

  task automatic step(input bit rst, input bit rdy, input bit rv);
    logic [DW-1:0] rd;
    logic [N-1:0]  oh;
    int            w;
    bit            ev;
    @(posedge clk); #1;
    rd           = {$urandom, $urandom};
    rst_i        = rst;
    mem_ready_i  = rdy;
    mem_rvalid_i = rv;
    mem_rdata_i  = rd;
    req_valid_i  = pend;
    for (int i = 0; i < N; i++) begin
      req_addr_i[i*AW +: AW]  = paddr[i];
      req_we_i[i]             = pwe[i];
      req_wdata_i[i*DW +: DW] = pwdata[i];
      req_be_i[i*BW +: BW]    = pbe[i];
    end
    if (rst) begin
      cyc_q.push_back('{valid: 1'b0, err: err});
      out_q.delete();
      rr = 0; held = -1; err = 1'b0;
    end else begin
      w = -1;
      if (out_q.size() < MO) begin
        if (held >= 0) w = held;
        else for (int k = 0; k < N; k++) if (w < 0 && pend[(rr + k) % N]) w = (rr + k) % N;
      end
      ev = (w >= 0);
      cyc_q.push_back('{valid: ev, err: err});
      if (rv) begin
        if (out_q.size() > 0) begin
          oh = '0; oh[out_q[0]] = 1'b1;
          rsp_q.push_back('{owner: oh, rdata: rd});
          void'(out_q.pop_front());
        end else err = 1'b1;
      end
      if (ev && rdy) begin
        oh = '0; oh[w] = 1'b1;
        grant_q.push_back('{ready: oh, addr: paddr[w], we: pwe[w], wdata: pwdata[w], be: pbe[w]});
        out_q.push_back(w);
        rr = (w + 1) % N; held = -1; pend[w] = 1'b0;
      end else if (ev) held = w;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && out_q.size() > 0; i++) step(1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: one cycle record per stimulus cycle, plus grant/response queues popped on DUT strobes.
  initial begin
    cyc_t c; grant_t g; rsp_t r;
    forever begin
      @(negedge clk);
      if (cyc_q.size() > 0) begin
        c = cyc_q.pop_front();
        chk(mem_valid_o === c.valid, "mem_valid", 64'(mem_valid_o), 64'(c.valid));
        chk(proto_err_o === c.err, "proto_err", 64'(proto_err_o), 64'(c.err));
        if (!c.valid) chk(req_ready_o === '0 && mem_addr_o === '0, "idle_outputs", mem_addr_o, 64'(req_ready_o));
      end
      if (mem_valid_o === 1'b1 && mem_ready_i === 1'b1) begin
        if (grant_q.size() == 0) chk(1'b0, "unexpected_grant", 64'(req_ready_o), 64'd0);
        else begin
          g = grant_q.pop_front();
          chk(req_ready_o === g.ready, "grant_ready", 64'(req_ready_o), 64'(g.ready));
          chk(mem_addr_o === g.addr && mem_we_o === g.we && mem_wdata_o === g.wdata && mem_be_o === g.be,
              "grant_fields", mem_addr_o, g.addr);
        end
      end else if (grant_q.size() > 0) begin
        g = grant_q.pop_front();
        chk(1'b0, "missing_grant", 64'(req_ready_o), 64'(g.ready));
      end
      if (rsp_valid_o !== '0) begin
        if (rsp_q.size() == 0) chk(1'b0, "unexpected_rsp", 64'(rsp_valid_o), 64'd0);
        else begin
          r = rsp_q.pop_front();
          chk(rsp_valid_o === r.owner, "rsp_owner", 64'(rsp_valid_o), 64'(r.owner));
          chk(rsp_rdata_o === r.rdata, "rsp_rdata", rsp_rdata_o, r.rdata);
        end
      end else if (rsp_q.size() > 0) begin
        r = rsp_q.pop_front();
        chk(1'b0, "missing_rsp", 64'(rsp_valid_o), 64'(r.owner));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i = 1'b1; mem_ready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    req_valid_i = '0; req_addr_i = '0; req_we_i = '0; req_wdata_i = '0; req_be_i = '0;
    pend = '0; rr = 0; held = -1; err = 1'b0;
    for (int i = 0; i < N; i++) begin
      paddr[i] = '0; pwe[i] = 1'b0; pwdata[i] = '0; pbe[i] = '0;
    end
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);

    // All valid, ready high: grants 0,1,2,0 then responses in that order.
    for (int c = 0; c < 4; c++) begin
      if (c < 3) refill(); else new_req(0, 1'b0, 8'hFF);
      step(1'b0, 1'b1, 1'b0);
    end
    pend = '0;
    drain();

    // Req1 stalls four cycles; req0 arrives on the second and must wait its turn.
    new_req(1, 1'b0, 8'hFF);
    step(1'b0, 1'b0, 1'b0);
    new_req(0, 1'b0, 8'hFF);
    for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    drain();

    // Fill all slots, observe the port closed, free one slot, then one grant resumes.
    for (int c = 0; c < MO; c++) begin refill(); step(1'b0, 1'b1, 1'b0); end
    for (int c = 0; c < 3; c++) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    pend = '0;
    drain();

    // Store from req2 followed by a load from req0.
    new_req(2, 1'b1, 8'h0F);
    step(1'b0, 1'b1, 1'b0);
    new_req(0, 1'b0, 8'hFF);
    step(1'b0, 1'b1, 1'b0);
    drain();

    // Response with nothing outstanding sets the sticky error; reset clears it.
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // Reset while locked with three outstanding.
    for (int c = 0; c < 3; c++) begin refill(); step(1'b0, 1'b1, 1'b0); end
    pend = '0;
    new_req(1, 1'b0, 8'hFF);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    pend = '0;
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    refill();
    step(1'b0, 1'b1, 1'b0);
    pend = '0;
    drain();

    // Randomized traffic with alternating response pressure to hit the full condition.
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 99) < 35)
          new_req(i, 1'($urandom_range(0, 1)), 8'($urandom));
      step(1'b0, $urandom_range(0, 99) < 65,
           out_q.size() > 0 && $urandom_range(0, 99) < (((c / 100) % 2 == 1) ? 12 : 45));
    end
    for (int c = 0; c < 100 && (pend != '0 || out_q.size() > 0); c++)
      step(1'b0, 1'b1, out_q.size() > 0);
    chk(pend == '0 && out_q.size() == 0, "drain_done", 64'(out_q.size()), 64'd0);

    @(negedge clk);
    @(negedge clk);
    chk(grant_q.size() == 0 && rsp_q.size() == 0 && cyc_q.size() == 0, "queues_empty",
        64'(grant_q.size() + rsp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
